key_link_arbiter: RTL and testbench

Shares the single-bit serial key link between two key-code sources. Arbitrates round-robin between two requesters and serializes the winner's 24-bit key code as six framed nibbles. Each nibble is sent as a start bit, 4 data bits LSB first, then a stop bit, so the downstream serial nibble receiver rebuilds the exact code in its 24-bit shift buffer. It sits between the keypad/scan front-ends and the receiver's serial input, and owns all sequencing of that line.

---
 rtl/key_link_pkg.sv | 17 +
 rtl/key_link_rr_arb.sv | 49 ++++
 rtl/key_link_arbiter.sv | 158 +++++++++++++++
 tb/tb_key_link_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_link_pkg.sv
// rtl/key_link_pkg.sv - shared state encoding and line levels for the serial key link
package key_link_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int   NIBBLE_W  = 4;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/key_link_rr_arb.sv
// rtl/key_link_rr_arb.sv - two-way round-robin arbiter with grant enable
// The pointer names the requester that wins a tie; it flips to the other side after each grant.
module key_link_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (gnt_en) begin
      if (prio_q == 1'b0) begin
        if (req[0]) begin
          gnt = 2'b01;
        end else if (req[1]) begin
          gnt = 2'b10;
        end
      end else begin
        if (req[1]) begin
          gnt = 2'b10;
        end else if (req[0]) begin
          gnt = 2'b01;
        end
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

endmodule

// File: rtl/key_link_arbiter.sv
// rtl/key_link_arbiter.sv - shares the serial key link between two sources
// Each granted code goes out as framed nibbles (start, 4 data LSB first, stop), MS nibble first.
module key_link_arbiter
  import key_link_pkg::*;
#(
  parameter int  NIBBLES = 6,
  parameter int  GAP_CYC = 2,
  localparam int CODE_W  = 4 * NIBBLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [CODE_W-1:0] code0,
  input  logic              req1,
  input  logic [CODE_W-1:0] code1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              tx_bit,
  output logic              busy,
  output logic              done,
  output logic              owner
);

  localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [2:0]          nib_cnt_q, nib_cnt_d;
  logic [1:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                tx_bit_q, tx_bit_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                owner_q, owner_d;

  logic [1:0]          arb_gnt;
  logic                arb_en;
  logic                grant;
  logic                last_nib;
  logic [NIBBLE_W-1:0] cur_nib;

  assign arb_en   = (state_q == IDLE);
  assign grant    = |arb_gnt;
  assign last_nib = (nib_cnt_q == LAST_NIB);
  assign cur_nib  = shift_q[CODE_W-1 -: NIBBLE_W];

  key_link_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1, req0}),
    .gnt_en (arb_en),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      nib_cnt_q <= 3'd0;
      bit_cnt_q <= 2'd0;
      gap_cnt_q <= 4'd0;
      tx_bit_q  <= IDLE_LVL;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      nib_cnt_q <= nib_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      tx_bit_q  <= tx_bit_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      owner_q   <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = START;
      START:   state_d = DATA;
      DATA:    if (bit_cnt_q == 2'd3) state_d = STOP;
      STOP: begin
        if (!last_nib) begin
          state_d = START;
        end else if (GAP_CYC == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      GAP:     if (gap_cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    nib_cnt_d = nib_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt[0]) begin
          shift_d   = code0;
          nib_cnt_d = 3'd0;
        end else if (arb_gnt[1]) begin
          shift_d   = code1;
          nib_cnt_d = 3'd0;
        end
      end
      START: bit_cnt_d = 2'd0;
      DATA:  if (bit_cnt_q != 2'd3) bit_cnt_d = bit_cnt_q + 2'd1;
      STOP: begin
        if (!last_nib) begin
          shift_d   = shift_q << NIBBLE_W;
          nib_cnt_d = nib_cnt_q + 3'd1;
        end else begin
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP:   if (gap_cnt_q != 4'd0) gap_cnt_d = gap_cnt_q - 4'd1;
      default: ;
    endcase
  end

  // Outputs follow the current state one edge later, so the start bit appears the edge after gnt.
  always_comb begin
    case (state_q)
      START:     tx_bit_d = START_LVL;
      DATA:      tx_bit_d = cur_nib[bit_cnt_q];
      STOP, GAP: tx_bit_d = STOP_LVL;
      default:   tx_bit_d = IDLE_LVL;
    endcase
    gnt0_d  = arb_gnt[0];
    gnt1_d  = arb_gnt[1];
    owner_d = grant ? arb_gnt[1] : owner_q;
    busy_d  = (state_q != IDLE) || grant;
    done_d  = (state_q == STOP) && last_nib;
  end

  assign tx_bit = tx_bit_q;
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_key_link_arbiter.sv
// tb/tb_key_link_arbiter.sv - scoreboard bench for key_link_arbiter (GAP_CYC=2 and GAP_CYC=0 instances)
module tb_key_link_arbiter;

  typedef struct packed {
    logic [23:0] code;
    logic        owner;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        req0_v  [2];
  logic        req1_v  [2];
  logic [23:0] code0_v [2];
  logic [23:0] code1_v [2];
  logic        gnt0_v  [2];
  logic        gnt1_v  [2];
  logic        tx_v    [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        owner_v [2];

  int total = 0;
  int bad   = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int          rx_st   [2];
  int          rx_bits [2];
  int          rx_nib  [2];
  logic [3:0]  rx_cur  [2];
  logic [23:0] key_buf [2];
  exp_t        mon_e;
  bit          mon_have;

  always #5 clk = ~clk;

  key_link_arbiter #(.NIBBLES(6), .GAP_CYC(2)) u_dut (
    .clk(clk), .rst(rst_v[0]), .req0(req0_v[0]), .code0(code0_v[0]),
    .req1(req1_v[0]), .code1(code1_v[0]), .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]),
    .tx_bit(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .owner(owner_v[0])
  );

  key_link_arbiter #(.NIBBLES(6), .GAP_CYC(0)) u_dut_gap0 (
    .clk(clk), .rst(rst_v[1]), .req0(req0_v[1]), .code0(code0_v[1]),
    .req1(req1_v[1]), .code1(code1_v[1]), .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]),
    .tx_bit(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .owner(owner_v[1])
  );

  // Serial nibble receiver model: rebuilds 24-bit codes from the line and checks them against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d] !== 1'b1) begin
        rx_st[d]  = 0;
        rx_nib[d] = 0;
      end else begin
        case (rx_st[d])
          0: if (tx_v[d] === 1'b0) begin
               rx_st[d]   = 1;
               rx_bits[d] = 0;
             end
          1: begin
               rx_cur[d][rx_bits[d]] = tx_v[d];
               rx_bits[d]++;
               if (rx_bits[d] == 4) rx_st[d] = 2;
             end
          default: begin
               rx_st[d] = 0;
               total++;
               if (tx_v[d] !== 1'b1) begin
                 bad++;
                 $display("FAIL stop_bit dut%0d: got %b want 1", d, tx_v[d]);
               end
               key_buf[d] = {key_buf[d][19:0], rx_cur[d]};
               rx_nib[d]++;
               if (rx_nib[d] == 6) begin
                 rx_nib[d] = 0;
                 mon_have  = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                 total++;
                 if (!mon_have) begin
                   bad++;
                   $display("FAIL unexpected_frame dut%0d: got code %h want none", d, key_buf[d]);
                 end else begin
                   if (d == 0) mon_e = exp_q0.pop_front();
                   else        mon_e = exp_q1.pop_front();
                   if (key_buf[d] !== mon_e.code) begin
                     bad++;
                     $display("FAIL rx_code dut%0d: got %h want %h", d, key_buf[d], mon_e.code);
                   end
                   total++;
                   if (owner_v[d] !== mon_e.owner) begin
                     bad++;
                     $display("FAIL frame_owner dut%0d: got %b want %b", d, owner_v[d], mon_e.owner);
                   end
                 end
               end
             end
        endcase
      end
    end
  end

  task automatic wait_gnt(input int d, input int which, input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (((which == 0) ? gnt0_v[d] : gnt1_v[d]) === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy_v[d] === 1'b0 && ((d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_v[d]  = 1'b0;
    req0_v[d] = 1'b0;
    req1_v[d] = 1'b0;
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_v[d] = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = {tx_v[d], gnt0_v[d], gnt1_v[d], busy_v[d], done_v[d], owner_v[d]};
      total++;
      if (got !== 6'b100000) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got {tx,g0,g1,busy,done,owner}=%b want 100000", d, got);
      end
    end
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [23:0] c;
    logic [3:0]  nib;
    logic        eb;
    int          w, n, pos;
    bit          ok;
    c = 24'hA5C317;
    exp_q0.push_back({c, 1'b0});
    req0_v[0]  = 1'b1;
    code0_v[0] = c;
    wait_gnt(0, 0, 20, w);
    req0_v[0] = 1'b0;
    total++;
    if (w < 0) begin
      bad++;
      $display("FAIL single_gnt0: got no gnt0 want pulse within 20 cycles");
    end else begin
      total++;
      if ({busy_v[0], owner_v[0], tx_v[0]} !== 3'b101) begin
        bad++;
        $display("FAIL single_grant_state: got {busy,owner,tx}=%b want 101", {busy_v[0], owner_v[0], tx_v[0]});
      end
      for (int j = 1; j <= 39; j++) begin
        @(negedge clk);
        if (j <= 36) begin
          n   = (j - 1) / 6;
          pos = (j - 1) % 6;
          nib = c[23 - 4*n -: 4];
          if (pos == 0)      eb = 1'b0;
          else if (pos == 5) eb = 1'b1;
          else               eb = nib[pos-1];
          total++;
          if (tx_v[0] !== eb) begin
            bad++;
            $display("FAIL single_tx_bit j=%0d: got %b want %b", j, tx_v[0], eb);
          end
        end
        if (j == 35 || j == 36) begin
          total++;
          if (done_v[0] !== (j == 36)) begin
            bad++;
            $display("FAIL single_done j=%0d: got %b want %b", j, done_v[0], (j == 36));
          end
        end
        if (j == 38 || j == 39) begin
          total++;
          if (busy_v[0] !== (j == 38)) begin
            bad++;
            $display("FAIL single_busy j=%0d: got %b want %b", j, busy_v[0], (j == 38));
          end
        end
      end
    end
    wait_drain(0, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_drain: got pending=%0d want 0", exp_q0.size());
    end
  endtask

  task automatic test_contention();
    int w0, w1;
    bit ok;
    do_reset(0);
    exp_q0.push_back({24'h0F1E2D, 1'b0});
    exp_q0.push_back({24'h123456, 1'b1});
    req0_v[0] = 1'b1; code0_v[0] = 24'h0F1E2D;
    req1_v[0] = 1'b1; code1_v[0] = 24'h123456;
    wait_gnt(0, 0, 20, w0);
    req0_v[0] = 1'b0;
    total++;
    if (w0 < 0 || gnt1_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL contention_first: got wait=%0d gnt1=%b want gnt0 alone", w0, gnt1_v[0]);
    end
    wait_gnt(0, 1, 100, w1);
    req1_v[0] = 1'b0;
    total++;
    if (w1 != 39) begin
      bad++;
      $display("FAIL contention_spacing: got %0d cycles want 39", w1);
    end
    total++;
    if (owner_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL contention_owner: got %b want 1", owner_v[0]);
    end
    wait_drain(0, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL contention_drain: got pending=%0d want 0", exp_q0.size());
    end
  endtask

  task automatic test_fairness();
    int w;
    bit ok;
    logic exp_id;
    do_reset(0);
    for (int f = 0; f < 4; f++) exp_q0.push_back((f % 2 == 0) ? {24'hAAAA55, 1'b0} : {24'h55AAAA, 1'b1});
    req0_v[0] = 1'b1; code0_v[0] = 24'hAAAA55;
    req1_v[0] = 1'b1; code1_v[0] = 24'h55AAAA;
    for (int f = 0; f < 4; f++) begin
      exp_id = (f % 2 == 1);
      w = -1;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (gnt0_v[0] === 1'b1 || gnt1_v[0] === 1'b1) begin
          w = i;
          break;
        end
      end
      total++;
      if (w < 0) begin
        bad++;
        $display("FAIL fair_timeout f=%0d: got no grant want grant within 60", f);
      end else begin
        total++;
        if ({gnt1_v[0], gnt0_v[0]} !== (exp_id ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL fair_grant f=%0d: got %b want %b", f, {gnt1_v[0], gnt0_v[0]}, (exp_id ? 2'b10 : 2'b01));
        end
        total++;
        if (owner_v[0] !== exp_id) begin
          bad++;
          $display("FAIL fair_owner f=%0d: got %b want %b", f, owner_v[0], exp_id);
        end
      end
    end
    req0_v[0] = 1'b0;
    req1_v[0] = 1'b0;
    wait_drain(0, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fair_drain: got pending=%0d want 0", exp_q0.size());
    end
  endtask

  task automatic test_late_request();
    int w0, w1;
    bit ok;
    do_reset(0);
    exp_q0.push_back({24'hC0FFEE, 1'b0});
    req0_v[0] = 1'b1; code0_v[0] = 24'hC0FFEE;
    wait_gnt(0, 0, 20, w0);
    req0_v[0]  = 1'b0;
    code0_v[0] = 24'h111111;
    total++;
    if (w0 < 0) begin
      bad++;
      $display("FAIL late_gnt0: got no gnt0 want pulse");
    end
    repeat (10) @(negedge clk);
    exp_q0.push_back({24'hABCDEF, 1'b1});
    req1_v[0] = 1'b1; code1_v[0] = 24'hABCDEF;
    wait_gnt(0, 1, 100, w1);
    req1_v[0] = 1'b0;
    total++;
    if (w1 != 29) begin
      bad++;
      $display("FAIL late_gnt1_timing: got %0d want 29", w1);
    end
    wait_drain(0, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL late_drain: got pending=%0d want 0", exp_q0.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    bit ok;
    do_reset(0);
    req0_v[0] = 1'b1; code0_v[0] = 24'hFEDCBA;
    wait_gnt(0, 0, 20, w);
    req0_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if ({tx_v[0], busy_v[0]} !== 2'b01) begin
      bad++;
      $display("FAIL midrst_before: got {tx,busy}=%b want 01", {tx_v[0], busy_v[0]});
    end
    rst_v[0] = 1'b0;
    #1;
    total++;
    if ({tx_v[0], busy_v[0], done_v[0], owner_v[0]} !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_abort: got {tx,busy,done,owner}=%b want 1000", {tx_v[0], busy_v[0], done_v[0], owner_v[0]});
    end
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    exp_q0.push_back({24'h369CF0, 1'b0});
    req0_v[0] = 1'b1; code0_v[0] = 24'h369CF0;
    wait_gnt(0, 0, 20, w);
    req0_v[0] = 1'b0;
    total++;
    if (w < 0) begin
      bad++;
      $display("FAIL midrst_regrant: got no gnt0 want pulse");
    end
    wait_drain(0, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_drain: got pending=%0d want 0", exp_q0.size());
    end
  endtask

  task automatic test_gap0();
    int w0;
    bit ok;
    do_reset(1);
    exp_q1.push_back({24'hA1B2C3, 1'b0});
    exp_q1.push_back({24'hD4E5F6, 1'b1});
    req0_v[1] = 1'b1; code0_v[1] = 24'hA1B2C3;
    req1_v[1] = 1'b1; code1_v[1] = 24'hD4E5F6;
    wait_gnt(1, 0, 20, w0);
    req0_v[1] = 1'b0;
    total++;
    if (w0 < 0) begin
      bad++;
      $display("FAIL gap0_gnt0: got no gnt0 want pulse");
    end else begin
      for (int j = 1; j <= 38; j++) begin
        @(negedge clk);
        if (j == 36) begin
          total++;
          if ({tx_v[1], done_v[1]} !== 2'b11) begin
            bad++;
            $display("FAIL gap0_last_stop: got {tx,done}=%b want 11", {tx_v[1], done_v[1]});
          end
        end
        if (j == 37) begin
          req1_v[1] = 1'b0;
          total++;
          if ({tx_v[1], gnt1_v[1]} !== 2'b11) begin
            bad++;
            $display("FAIL gap0_regrant: got {tx,gnt1}=%b want 11", {tx_v[1], gnt1_v[1]});
          end
        end
        if (j == 38) begin
          total++;
          if (tx_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL gap0_second_start: got %b want 0", tx_v[1]);
          end
        end
      end
    end
    req1_v[1] = 1'b0;
    wait_drain(1, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL gap0_drain: got pending=%0d want 0", exp_q1.size());
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d]   = 1'b0;
      req0_v[d]  = 1'b0;
      req1_v[d]  = 1'b0;
      code0_v[d] = 24'h0;
      code1_v[d] = 24'h0;
      rx_st[d]   = 0;
      rx_bits[d] = 0;
      rx_nib[d]  = 0;
      rx_cur[d]  = 4'h0;
      key_buf[d] = 24'h0;
    end
    test_reset();
    test_single_frame();
    test_contention();
    test_fairness();
    test_late_request();
    test_reset_mid_frame();
    test_gap0();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
